// File: rtl/sonic_pkg.sv
// Shared types for the ultrasonic ping scheduler: FSM states, beam angle
// type and the per-ping result record layout.
package sonic_pkg;

    localparam int ANGLE_W = 8;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BURST,
        LISTEN,
        REPORT
    } state_t;

    typedef logic signed [ANGLE_W-1:0] angle_t;

    typedef struct packed {
        angle_t            angle;
        logic [DATA_W-1:0] range;
        logic              hit;
        logic [DATA_W-1:0] velocity;
        logic              towards;
    } ping_result_t;

endpackage

// File: rtl/ping_timer.sv
// Loadable down-counter shared by the SETTLE, BURST and LISTEN phases.
// done_out is high while the count sits at zero, i.e. on the last cycle
// of a phase that was loaded with (length - 1).
module ping_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] count_out,
    output logic             done_out
);

    logic [WIDTH-1:0] cnt_q;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else if (load_in) begin
            cnt_q <= value_in;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_out = cnt_q;
    assign done_out  = (cnt_q == '0);

endmodule

// File: rtl/ping_sweep_scheduler.sv
// Ping cycle sequencer: steer beam, fire burst, listen, capture the first
// range/velocity result and hand one record per ping to the readout logic.
module ping_sweep_scheduler
    import sonic_pkg::*;
#(
    parameter int BURST_CYCLES  = 524288,
    parameter int PERIOD_CYCLES = 16777216,
    parameter int SETTLE_CYCLES = 1024,
    parameter int ANGLE_WIDTH   = ANGLE_W,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int DATA_WIDTH    = DATA_W
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic                          sweep_mode_in,
    input  logic signed [ANGLE_WIDTH-1:0] static_angle_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_start_out,
    output logic                          burst_active_out,
    output logic                          listen_active_out,
    input  logic                          tof_valid_in,
    input  logic        [DATA_WIDTH-1:0]  range_in,
    input  logic                          vel_valid_in,
    input  logic        [DATA_WIDTH-1:0]  velocity_in,
    input  logic                          towards_in,
    output logic                          result_valid_out,
    input  logic                          result_ready_in,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic        [DATA_WIDTH-1:0]  result_range_out,
    output logic                          result_hit_out,
    output logic        [DATA_WIDTH-1:0]  result_velocity_out,
    output logic                          result_towards_out,
    output logic                          sweep_done_out
);

    localparam int TW = $clog2(PERIOD_CYCLES) + 1;
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] BURST_LD  = TW'(BURST_CYCLES - 1);
    localparam logic [TW-1:0] LISTEN_LD = TW'(PERIOD_CYCLES - BURST_CYCLES - 1);

    localparam logic signed [ANGLE_WIDTH-1:0] MIN_A  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] MAX_A  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   MAX_X  = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   STEP_X = (ANGLE_WIDTH+1)'(ANGLE_STEP);

    // One extra bit so the step past ANGLE_MAX cannot wrap before the compare.
    function automatic logic signed [ANGLE_WIDTH-1:0] step_angle(
        input logic signed [ANGLE_WIDTH-1:0] a
    );
        logic signed [ANGLE_WIDTH:0] s;
        s = $signed({a[ANGLE_WIDTH-1], a}) + STEP_X;
        if (s > MAX_X) begin
            return MIN_A;
        end
        return s[ANGLE_WIDTH-1:0];
    endfunction

    state_t                         state_q, state_d;
    logic signed [ANGLE_WIDTH-1:0]  angle_q, angle_d;
    logic                           mode_q, mode_d;
    logic        [DATA_WIDTH-1:0]   range_q, range_d;
    logic                           hit_q, hit_d;
    logic        [DATA_WIDTH-1:0]   vel_q, vel_d;
    logic                           tow_q, tow_d;
    logic                           vseen_q, vseen_d;

    logic                           tmr_load;
    logic        [TW-1:0]           tmr_value;
    logic        [TW-1:0]           tmr_count;
    logic                           tmr_done;
    logic                           first_burst;
    logic                           in_report;
    logic                           sweep_done;

    ping_timer #(.WIDTH(TW)) u_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (tmr_load),
        .value_in  (tmr_value),
        .count_out (tmr_count),
        .done_out  (tmr_done)
    );

    assign first_burst = (state_q == BURST) && (tmr_count == BURST_LD);
    assign in_report   = (state_q == REPORT);

    // Phase sequencing, timer reloads on each entry, and angle/mode updates.
    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        angle_d    = angle_q;
        mode_d     = mode_q;
        sweep_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d   = SETTLE;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LD;
                    mode_d    = sweep_mode_in;
                    angle_d   = sweep_mode_in ? MIN_A : static_angle_in;
                end
            end
            SETTLE: begin
                if (!enable_in) begin
                    state_d = IDLE;
                end else if (tmr_done) begin
                    state_d   = BURST;
                    tmr_load  = 1'b1;
                    tmr_value = BURST_LD;
                end
            end
            BURST: begin
                if (tmr_done) begin
                    state_d   = LISTEN;
                    tmr_load  = 1'b1;
                    tmr_value = LISTEN_LD;
                end
            end
            LISTEN: begin
                if (tmr_done) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (result_ready_in) begin
                    sweep_done = mode_q && (angle_q == MAX_A);
                    // A static ping followed by sweep mode restarts the span.
                    if (!sweep_mode_in) begin
                        angle_d = static_angle_in;
                    end else if (!mode_q) begin
                        angle_d = MIN_A;
                    end else begin
                        angle_d = step_angle(angle_q);
                    end
                    if (enable_in) begin
                        state_d   = SETTLE;
                        tmr_load  = 1'b1;
                        tmr_value = SETTLE_LD;
                        mode_d    = sweep_mode_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // First-echo capture: cleared at burst start, latched once per field in LISTEN.
    always_comb begin
        range_d = range_q;
        hit_d   = hit_q;
        vel_d   = vel_q;
        tow_d   = tow_q;
        vseen_d = vseen_q;
        if (first_burst) begin
            range_d = '0;
            hit_d   = 1'b0;
            vel_d   = '0;
            tow_d   = 1'b0;
            vseen_d = 1'b0;
        end else if (state_q == LISTEN) begin
            if (tof_valid_in && !hit_q) begin
                range_d = range_in;
                hit_d   = 1'b1;
            end
            if (vel_valid_in && !vseen_q) begin
                vel_d   = velocity_in;
                tow_d   = towards_in;
                vseen_d = 1'b1;
            end
        end
    end

    // State, angle and capture registers; reset discards any partial ping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            angle_q <= MIN_A;
            mode_q  <= 1'b0;
            range_q <= '0;
            hit_q   <= 1'b0;
            vel_q   <= '0;
            tow_q   <= 1'b0;
            vseen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            mode_q  <= mode_d;
            range_q <= range_d;
            hit_q   <= hit_d;
            vel_q   <= vel_d;
            tow_q   <= tow_d;
            vseen_q <= vseen_d;
        end
    end

    assign beam_angle_out      = angle_q;
    assign burst_start_out     = first_burst;
    assign burst_active_out    = (state_q == BURST);
    assign listen_active_out   = (state_q == LISTEN);
    assign result_valid_out    = in_report;
    assign result_angle_out    = in_report ? angle_q : '0;
    assign result_range_out    = in_report ? range_q : '0;
    assign result_hit_out      = in_report && hit_q;
    assign result_velocity_out = in_report ? vel_q : '0;
    assign result_towards_out  = in_report && tow_q;
    assign sweep_done_out      = sweep_done;

endmodule

// File: tb/tb_ping_sweep_scheduler.sv
// Directed bench for ping_sweep_scheduler with short timing parameters.
module tb_ping_sweep_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               sweep_mode;
    logic signed [7:0]  static_angle;
    logic signed [7:0]  beam_angle;
    logic               burst_start, burst_active, listen_active;
    logic               tof_valid;
    logic        [15:0] range_v;
    logic               vel_valid;
    logic        [15:0] velocity;
    logic               towards;
    logic               res_valid;
    logic               res_ready;
    logic signed [7:0]  res_angle;
    logic        [15:0] res_range;
    logic               res_hit;
    logic        [15:0] res_vel;
    logic               res_tow;
    logic               sweep_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_ref = -1;
    int prev_start = -1;
    int sd_count = 0;

    ping_sweep_scheduler #(
        .BURST_CYCLES (4),
        .PERIOD_CYCLES(16),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .enable_in          (enable),
        .sweep_mode_in      (sweep_mode),
        .static_angle_in    (static_angle),
        .beam_angle_out     (beam_angle),
        .burst_start_out    (burst_start),
        .burst_active_out   (burst_active),
        .listen_active_out  (listen_active),
        .tof_valid_in       (tof_valid),
        .range_in           (range_v),
        .vel_valid_in       (vel_valid),
        .velocity_in        (velocity),
        .towards_in         (towards),
        .result_valid_out   (res_valid),
        .result_ready_in    (res_ready),
        .result_angle_out   (res_angle),
        .result_range_out   (res_range),
        .result_hit_out     (res_hit),
        .result_velocity_out(res_vel),
        .result_towards_out (res_tow),
        .sweep_done_out     (sweep_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (sweep_done) sd_count <= sd_count + 1;

    typedef struct {
        bit               sweep;
        logic signed [7:0] stat;
        int               t1;
        logic [15:0]      r1;
        int               t2;
        logic [15:0]      r2;
        int               tv;
        logic [15:0]      v;
        bit               tw;
        bit               btof;
        int               hold;
        bit               drop;
        logic signed [7:0] e_ang;
        logic [15:0]      e_rng;
        bit               e_hit;
        logic [15:0]      e_vel;
        bit               e_tw;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(bit sw, logic signed [7:0] st, int t1, logic [15:0] r1,
                                int t2, logic [15:0] r2, int tv, logic [15:0] v, bit tw,
                                bit btof, int hold, bit drop, logic signed [7:0] ea,
                                logic [15:0] er, bit eh, logic [15:0] ev, bit et);
        vec_t x;
        x.sweep = sw;   x.stat = st;  x.t1 = t1;   x.r1 = r1;   x.t2 = t2;  x.r2 = r2;
        x.tv = tv;      x.v = v;      x.tw = tw;   x.btof = btof;
        x.hold = hold;  x.drop = drop;
        x.e_ang = ea;   x.e_rng = er; x.e_hit = eh; x.e_vel = ev; x.e_tw = et;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_echo();
        tof_valid = 1'b0; range_v = '0; vel_valid = 1'b0; velocity = '0; towards = 1'b0;
    endtask

    function automatic bit all_quiet();
        return !burst_start && !burst_active && !listen_active && !res_valid &&
               !res_hit && !res_tow && !sweep_done && res_range == 16'h0 &&
               res_vel == 16'h0 && res_angle == 8'sd0;
    endfunction

    // One full ping: stimulus in BURST/LISTEN, record check, optional back-pressure.
    task automatic run_ping(input vec_t v, input vec_t nxt, input int exp_space);
        bit got;
        int bc;
        int lc;
        bit ok;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (burst_start) begin got = 1'b1; break; end
        end
        check("burst_start_seen", 32'(got), 32'd1);
        if (!got) return;
        if (lat_ref >= 0) check("enable_to_burst", 32'(cyc - lat_ref), 32'd3);
        lat_ref = -1;
        if (exp_space > 0) check("ping_spacing", 32'(cyc - prev_start), 32'(exp_space));
        prev_start = cyc;
        check("beam_angle", 32'(beam_angle), 32'(v.e_ang));
        if (v.hold > 0) res_ready = 1'b0;
        bc = 0; lc = 0; got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (n > 0) @(negedge clk);
            if (res_valid) begin got = 1'b1; break; end
            clear_echo();
            if (burst_active) begin
                bc++;
                if (v.btof) begin tof_valid = 1'b1; range_v = 16'h0BAD; end
            end
            if (listen_active) begin
                lc++;
                if (lc == v.t1) begin tof_valid = 1'b1; range_v = v.r1; end
                else if (lc == v.t2) begin tof_valid = 1'b1; range_v = v.r2; end
                if (lc == v.tv) begin vel_valid = 1'b1; velocity = v.v; towards = v.tw; end
                if (v.drop && lc == 3) enable = 1'b0;
            end
        end
        clear_echo();
        check("result_valid_seen", 32'(got), 32'd1);
        check("burst_cycles", 32'(bc), 32'd4);
        check("listen_cycles", 32'(lc), 32'd12);
        check("rec_angle", 32'(res_angle), 32'(v.e_ang));
        check("rec_range", 32'(res_range), 32'(v.e_rng));
        check("rec_hit", 32'(res_hit), 32'(v.e_hit));
        check("rec_velocity", 32'(res_vel), 32'(v.e_vel));
        check("rec_towards", 32'(res_tow), 32'(v.e_tw));
        check("sweep_done", 32'(sweep_done),
              32'(v.hold == 0 && v.sweep && v.e_ang == 8'sd30));
        for (int j = 0; j < v.hold; j++) begin
            @(negedge clk);
            ok = res_valid && res_angle == v.e_ang && res_range == v.e_rng &&
                 res_hit == v.e_hit && res_vel == v.e_vel && res_tow == v.e_tw &&
                 !burst_start && !burst_active && !sweep_done;
            check("backpressure_hold", 32'(ok), 32'd1);
        end
        sweep_mode   = nxt.sweep;
        static_angle = nxt.stat;
        res_ready    = 1'b1;
        if (v.hold > 0) begin
            @(negedge clk);
            check("settle_after_release", 32'({res_valid, burst_active, listen_active}), 32'd0);
        end
    endtask

    initial begin
        bit got;
        bit ok;
        rst = 1'b1; enable = 1'b0; sweep_mode = 1'b1; static_angle = '0;
        res_ready = 1'b1;
        clear_echo();

        //              sw st  t1 r1       t2 r2       tv v        tw bt hold dr ang   rng      hit vel      tw
        tbl[0]  = mk(1, 0,  5, 16'h0123, 8, 16'h0456, 12, 16'h0042, 1, 1, 0,  0, -30, 16'h0123, 1, 16'h0042, 1);
        tbl[1]  = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0, -20, 16'h0000, 0, 16'h0000, 0);
        tbl[2]  = mk(1, 0,  1, 16'h0777, 0, 16'h0000, 1,  16'h0011, 0, 0, 0,  0, -10, 16'h0777, 1, 16'h0011, 0);
        tbl[3]  = mk(1, 0,  12,16'hFFFF, 0, 16'h0000, 0,  16'h0000, 0, 0, 50, 0,  0,  16'hFFFF, 1, 16'h0000, 0);
        tbl[4]  = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 3,  16'h8000, 1, 0, 0,  0,  10, 16'h0000, 0, 16'h8000, 1);
        tbl[5]  = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 1, 0,  0,  20, 16'h0000, 0, 16'h0000, 0);
        tbl[6]  = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0,  30, 16'h0000, 0, 16'h0000, 0);
        tbl[7]  = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0, -30, 16'h0000, 0, 16'h0000, 0);
        tbl[8]  = mk(0, 20, 2, 16'h1234, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0,  20, 16'h1234, 1, 16'h0000, 0);
        tbl[9]  = mk(0, 20, 0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0,  20, 16'h0000, 0, 16'h0000, 0);
        tbl[10] = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0, -30, 16'h0000, 0, 16'h0000, 0);
        tbl[11] = mk(1, 0,  4, 16'h00AA, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  1, -20, 16'h00AA, 1, 16'h0000, 0);
        tbl[12] = mk(1, 0,  0, 16'h0000, 0, 16'h0000, 0,  16'h0000, 0, 0, 0,  0, -30, 16'h0000, 0, 16'h0000, 0);

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(all_quiet()), 32'd1);
        check("reset_beam_angle", 32'(beam_angle), 32'(-8'sd30));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(all_quiet()), 32'd1);

        enable  = 1'b1;
        lat_ref = cyc;
        for (int i = 0; i < 13; i++) begin
            if (i == 12) begin
                // After the dropped-enable ping the block must sit in IDLE.
                ok = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (!all_quiet()) ok = 1'b0;
                end
                check("idle_after_drop", 32'(ok), 32'd1);
                enable  = 1'b1;
                lat_ref = cyc;
            end
            run_ping(tbl[i], tbl[(i < 12) ? i + 1 : i],
                     (i == 0 || i == 12) ? 0 : 19 + tbl[i-1].hold);
        end

        // Asynchronous reset in the middle of a burst.
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (burst_start) begin got = 1'b1; break; end
        end
        check("burst_before_reset", 32'(got), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(all_quiet()), 32'd1);
        check("async_reset_angle", 32'(beam_angle), 32'(-8'sd30));
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(all_quiet()), 32'd1);

        check("sweep_done_count", 32'(sd_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
